// File: rtl/board_pkg.sv
// Shared board-level definitions: debounce FSM encoding, board clock, cycle-count helper.
package board_pkg;

    localparam int FREQ_CLOCK_HZ = 12_000_000;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_PEND   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_PEND = 2'd3
    } db_state_t;

    function automatic int debounce_cycles(input int freq_hz, input int ms);
        return freq_hz / 1000 * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous board input; reset value selectable
// so an idle pad never looks like a transition when reset releases.
module sync_2ff #(
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronise, then require DEBOUNCE_CYCLES stable cycles
// before changing the level; emits registered one-cycle press/release pulses.
module button_debounce
    import board_pkg::*;
#(
    parameter int FREQ_CLOCK      = FREQ_CLOCK_HZ,
    parameter int DEBOUNCE_MS     = 20,
    parameter int DEBOUNCE_CYCLES = debounce_cycles(FREQ_CLOCK, DEBOUNCE_MS),
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    // DEBOUNCE_CYCLES must be at least 2 so the counter is at least one bit wide.
    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic sync_raw;
    logic sync_q;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (btn_in),
        .q_o (sync_raw)
    );

    assign sync_q = sync_raw ^ ACTIVE_LOW;

    db_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic             release_q, release_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RELEASED;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            RELEASED: begin
                if (sync_q) begin
                    state_d = PRESS_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            PRESS_PEND: begin
                // Any bounce back to released throws away the partial window.
                if (!sync_q) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = PRESSED;
                    level_d = 1'b1;
                    press_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!sync_q) begin
                    state_d = RELEASE_PEND;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            RELEASE_PEND: begin
                if (sync_q) begin
                    state_d   = PRESSED;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = RELEASED;
                    level_d   = 1'b0;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else begin
                    cnt_d     = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = RELEASED;
                cnt_d   = '0;
            end
        endcase
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

endmodule

// File: doc/button_debounce.md
# button_debounce

Debounces and synchronises one mechanical push-button on the board clock. Produces a clean level plus single-cycle press/release pulses. Sits directly upstream of the LED blinker, where `btn_press` selects blink modes or `btn_level` drives a gated restart. All outputs are synchronous to `clk`, so downstream stages never see bounce or metastability.

## Interface

Parameters:
- `FREQ_CLOCK`, 12_000_000: clock frequency in Hz.
- `DEBOUNCE_MS`, 20: required stable time in ms.
- `DEBOUNCE_CYCLES`, FREQ_CLOCK/1000*DEBOUNCE_MS (= 240_000): stable cycles required. Overridable directly; minimum 2.
- `ACTIVE_LOW`, 0: 1 means the pad reads 0 when pressed; the input is inverted after synchronisation.

Ports:
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset. One clock; reset is asynchronous and active-high.
- `btn_in`, in, 1: raw asynchronous button pad.
- `btn_level`, out, 1: debounced pressed level (1 = pressed).
- `btn_press`, out, 1: one-cycle pulse on each debounced press.
- `btn_release`, out, 1: one-cycle pulse on each debounced release.

## Operation

- Input path: `btn_in` goes through a 2-FF synchroniser, then the optional `ACTIVE_LOW` inversion. The result is `sync_q`.
- FSM states and counter:
  - States: RELEASED, PRESS_PEND, PRESSED, RELEASE_PEND.
  - Counter `cnt` has width $clog2(DEBOUNCE_CYCLES).
- RELEASED:
  - `sync_q`=1: go to PRESS_PEND, `cnt`<=1.
  - Otherwise stay, `cnt`<=0.
- PRESS_PEND:
  - `sync_q`=0: go to RELEASED, `cnt`<=0. Each bounce restarts the full window.
  - `sync_q`=1 and `cnt`==DEBOUNCE_CYCLES-1: go to PRESSED, `btn_level`<=1, `btn_press`<=1, `cnt`<=0.
  - Otherwise `cnt`<=`cnt`+1.
- PRESSED and RELEASE_PEND mirror RELEASED and PRESS_PEND with `sync_q` inverted. They end in `btn_level`<=0 and `btn_release`<=1.
- `btn_press` and `btn_release` are registered. Each is high for exactly one cycle, and they are never high in the same cycle.
- `cnt` never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- Reset (any time, including mid-window): state RELEASED, `cnt`=0, synchroniser FFs 0 (or 1 when `ACTIVE_LOW`=1). All outputs 0; no pulse on reset release.
- Button held during reset: after `rst` deasserts, a normal full debounce window runs, then `btn_press` fires once.

## Timing

- Synchroniser latency: 2 cycles. Debounce window: DEBOUNCE_CYCLES consecutive cycles with `sync_q` at the new value.
- Clean press:
  - `btn_in` rises before edge 0 and holds. `sync_q` is 1 after edge 1.
  - PRESS_PEND is entered at edge 2.
  - `btn_level` and `btn_press` go high after edge DEBOUNCE_CYCLES+1.
  - `btn_press` drops after the next edge.
- Release follows identical timing.
- One glitch cycle in a pending state restarts the window; total latency becomes (glitch end + DEBOUNCE_CYCLES + 2).
- Pulses shorter than DEBOUNCE_CYCLES after synchronisation never change `btn_level`.

## Structure

- Shared package `board_pkg`:
  - FSM state typedef (2-bit encoding).
  - `FREQ_CLOCK` default constant, shared with the blinker.
  - Helper function for the debounce cycle count.
- Sub-module `sync_2ff`: parameterised reset value, reused for every board input.
- The FSM and counter stay in `button_debounce`.

## Test plan

All scenarios use `DEBOUNCE_CYCLES`=8.

- Reset: hold `rst` with `btn_in`=0 -> all outputs 0. After release, 20 idle cycles -> no pulses.
- Clean press: `btn_in`=1 held from cycle 0 -> `btn_level` and `btn_press` rise after edge 9. `btn_press` is high exactly 1 cycle; no further pulses while held.
- Bouncy press: `btn_in` toggles 1,0,1,0,1 every 3 cycles, then holds 1 -> exactly one `btn_press`, 10 cycles after the final rise.
- Glitch rejection: 5-cycle high pulse on `btn_in` while RELEASED -> `btn_level` stays 0, no pulses.
- Release: from PRESSED, `btn_in`=0 held -> `btn_release` 1 cycle and `btn_level` low, 10 cycles later.
- Reset mid-window: `rst` asserted at `cnt`=5 in PRESS_PEND with `btn_in` held high.
  - During reset: outputs 0 immediately.
  - After reset release: `btn_press` only after a fresh 10-cycle window.
  - `ACTIVE_LOW`=1 variant: same sequence with `btn_in` inverted.
